// File: rtl/fetch_controller.sv
// Fetch stage sequencer: owns the fetch PC, the F->D register and a one-entry hold buffer.
// It talks to a variable-latency instruction memory over a req/ack handshake.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSrcE,
  input  logic [31:0]      PCTargetE,
  input  logic             StallD,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_f_q, pc_f_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      instr_d_q, instr_d_d;
  logic [31:0]      pc_d_q, pc_d_d;
  logic [31:0]      pc_plus4_d_q, pc_plus4_d_d;
  logic             valid_d_q, valid_d_d;
  logic [31:0]      hold_instr_q, hold_instr_d;
  logic [31:0]      hold_pc_q, hold_pc_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             d_free;
  logic             load_d;
  logic [31:0]      new_instr;
  logic [31:0]      new_pc;

  // Memory-facing outputs depend on state only, so ack may safely arrive in the same cycle.
  always_comb begin
    imem_req  = (state_q != S_HOLD);
    imem_addr = (state_q == S_DRAIN) ? req_addr_q : pc_f_q;
  end

  // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    req_addr_d   = req_addr_q;
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    wait_cnt_d   = wait_cnt_q;
    load_d       = 1'b0;
    new_instr    = 32'h0;
    new_pc       = 32'h0;
    d_free       = !StallD || !valid_d_q;

    case (state_q)
      S_FETCH: begin
        req_addr_d = pc_f_q;
        if (PCSrcE) begin
          pc_f_d = PCTargetE;
          if (!imem_ack) state_d = S_DRAIN;
        end else if (imem_ack) begin
          pc_f_d = pc_f_q + 32'd4;
          if (d_free) begin
            load_d    = 1'b1;
            new_instr = imem_rdata;
            new_pc    = pc_f_q;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_f_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_DRAIN: begin
        // The returning word belongs to the abandoned path and is discarded.
        if (PCSrcE) pc_f_d = PCTargetE;
        if (imem_ack) state_d = S_FETCH;
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_f_d       = PCTargetE;
          hold_instr_d = 32'h0;
          hold_pc_d    = 32'h0;
          state_d      = S_FETCH;
        end else if (d_free) begin
          load_d       = 1'b1;
          new_instr    = hold_instr_q;
          new_pc       = hold_pc_q;
          hold_instr_d = 32'h0;
          hold_pc_d    = 32'h0;
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // A redirect flushes D even when decode is stalled.
    if (PCSrcE) begin
      instr_d_d    = 32'h0;
      pc_d_d       = 32'h0;
      pc_plus4_d_d = 32'h0;
      valid_d_d    = 1'b0;
    end else if (load_d) begin
      instr_d_d    = new_instr;
      pc_d_d       = new_pc;
      pc_plus4_d_d = new_pc + 32'd4;
      valid_d_d    = 1'b1;
    end else if (d_free) begin
      instr_d_d = 32'h0;
      valid_d_d = 1'b0;
    end

    if (imem_req && !imem_ack && (wait_cnt_q != {CNT_W{1'b1}}))
      wait_cnt_d = wait_cnt_q + CNT_ONE;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_f_q       <= RESET_PC;
      req_addr_q   <= RESET_PC;
      instr_d_q    <= 32'h0;
      pc_d_q       <= 32'h0;
      pc_plus4_d_q <= 32'h0;
      valid_d_q    <= 1'b0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      req_addr_q   <= req_addr_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign InstrD   = instr_d_q;
  assign PCD      = pc_d_q;
  assign PCPlus4D = pc_plus4_d_q;
  assign ValidD   = valid_d_q;
  assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, hand-written corner sequences and
// random stimulus checked against a queue-based reference model of the fetch stage.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, PCSrcE, StallD, imem_ack;
  logic [31:0] PCTargetE, imem_rdata;

  logic        imem_req, imem_req_s;
  logic [31:0] imem_addr, imem_addr_s;
  logic [31:0] InstrD, PCD, PCPlus4D, InstrD_s, PCD_s, PCPlus4D_s;
  logic        ValidD, ValidD_s;
  logic [15:0] wait_cnt;
  logic [2:0]  wait_cnt_s;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .wait_cnt(wait_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  fetch_controller #(.RESET_PC(RESET_PC), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req(imem_req_s), .imem_addr(imem_addr_s), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrD(InstrD_s), .PCD(PCD_s), .PCPlus4D(PCPlus4D_s), .ValidD(ValidD_s), .wait_cnt(wait_cnt_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: D slot, a queue standing in for the hold buffer, and a drain flag.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } dslot_t;

  dslot_t      m_d;
  dslot_t      m_buf[$];
  logic [31:0] m_pc;
  logic [31:0] m_drain_addr;
  bit          m_drain;
  bit          m_init = 1'b0;
  int          m_wait;

  task automatic model_update(input bit r, input bit s, input bit p, input logic [31:0] tgt,
                              input bit a);
    bit     req, free;
    dslot_t nd;
    if (r) begin
      m_pc = RESET_PC; m_drain = 1'b0; m_drain_addr = RESET_PC;
      m_buf.delete(); m_d = '0; m_wait = 0; m_init = 1'b1;
      return;
    end
    req  = (m_buf.size() == 0);
    free = !s || !m_d.valid;
    if (req && !a) m_wait++;
    if (p) begin
      if (req && !m_drain && !a) begin
        m_drain = 1'b1;
        m_drain_addr = m_pc;
      end else if (m_drain && a) begin
        m_drain = 1'b0;
      end
      m_buf.delete();
      m_pc = tgt;
      m_d = '0;
    end else if (m_buf.size() != 0) begin
      if (free) m_d = m_buf.pop_front();
    end else if (m_drain) begin
      if (a) m_drain = 1'b0;
      if (free) begin m_d.valid = 1'b0; m_d.instr = 32'h0; end
    end else if (a) begin
      nd.valid = 1'b1; nd.instr = mem_word(m_pc); nd.pc = m_pc; nd.pc4 = m_pc + 32'd4;
      if (free) m_d = nd;
      else m_buf.push_back(nd);
      m_pc = m_pc + 32'd4;
    end else if (free) begin
      m_d.valid = 1'b0; m_d.instr = 32'h0;
    end
  endtask

  // One clock: drive inputs, check memory-side outputs, clock, check D-side outputs.
  task automatic step(input bit r, input bit s, input bit p, input logic [31:0] tgt,
                      input bit a, input bit garbage = 1'b0);
    rst = r; StallD = s; PCSrcE = p; PCTargetE = tgt; imem_ack = a;
    imem_rdata = garbage ? 32'hDEAD_BEEF : mem_word(imem_addr);
    if (!r && m_init) begin
      check("imem_req", imem_req, m_buf.size() == 0);
      check("imem_addr", imem_addr, m_drain ? m_drain_addr : m_pc);
    end
    model_update(r, s, p, tgt, a);
    @(posedge clk);
    #1;
    check("InstrD", InstrD, m_d.instr);
    check("PCD", PCD, m_d.pc);
    check("PCPlus4D", PCPlus4D, m_d.pc4);
    check("ValidD", ValidD, m_d.valid);
    check("wait_cnt", wait_cnt, (m_wait > 65535) ? 65535 : m_wait);
    check("wait_cnt_sat3", wait_cnt_s, (m_wait > 7) ? 7 : m_wait);
  endtask

  typedef struct {
    bit          rst, stall, pcsrc, ack;
    logic [31:0] tgt;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pcd;
    int          exp_wait;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; imem_ack = 1'b0;
    imem_rdata = 32'h0;

    // rst stall pcsrc ack tgt | req addr | valid pcd wait
    // zero-wait memory: one instruction per cycle
    vecs.push_back('{1, 0, 0, 1, 0, 1, 32'h00, 0, 32'h00, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h00, 1, 32'h00, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h04, 1, 32'h04, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h08, 1, 32'h08, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h0C, 1, 32'h0C, 0});
    // decode stall while address 8 returns
    vecs.push_back('{1, 0, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h00, 1, 32'h00, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h04, 1, 32'h04, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 1, 32'h08, 1, 32'h04, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 32'h0C, 1, 32'h04, 0});
    vecs.push_back('{0, 1, 0, 1, 0, 0, 32'h0C, 1, 32'h04, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 32'h0C, 1, 32'h08, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h0C, 1, 32'h0C, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h10, 1, 32'h10, 0});
    // two wait states per access
    vecs.push_back('{1, 0, 0, 0, 0, 1, 32'h00, 0, 32'h00, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 32'h00, 0, 32'h00, 1});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 32'h00, 0, 32'h00, 2});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h00, 1, 32'h00, 2});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 32'h04, 0, 32'h00, 3});
    vecs.push_back('{0, 0, 0, 0, 0, 1, 32'h04, 0, 32'h00, 4});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 32'h04, 1, 32'h04, 4});

    foreach (vecs[i]) begin
      if (!vecs[i].rst) begin
        check($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
        check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      end
      step(vecs[i].rst, vecs[i].stall, vecs[i].pcsrc, vecs[i].tgt, vecs[i].ack);
      check($sformatf("vec%0d_valid", i), ValidD, vecs[i].exp_valid);
      check($sformatf("vec%0d_pcd", i), PCD, vecs[i].exp_pcd);
      check($sformatf("vec%0d_wait", i), wait_cnt, vecs[i].exp_wait);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_instr", i), InstrD, mem_word(vecs[i].exp_pcd));
    end

    // Redirect while the request to 0x10 is outstanding: drain, drop, refetch at target.
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    check("drain_pre_pcd", PCD, 32'h0C);
    check("drain_pre_addr", imem_addr, 32'h10);
    step(0, 0, 1, 32'h100, 0);
    check("drain_flush_valid", ValidD, 1'b0);
    check("drain_req", imem_req, 1'b1);
    check("drain_addr", imem_addr, 32'h10);
    step(0, 0, 0, 0, 0);
    check("drain_wait_valid", ValidD, 1'b0);
    step(0, 0, 0, 0, 1);
    check("drain_drop_valid", ValidD, 1'b0);
    check("drain_next_addr", imem_addr, 32'h100);
    step(0, 0, 0, 0, 1);
    check("drain_target_pcd", PCD, 32'h100);
    check("drain_target_instr", InstrD, mem_word(32'h100));
    check("drain_wait_cnt", wait_cnt, 16'd2);

    // Redirect with decode stalled and the hold buffer full.
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    check("hold_req", imem_req, 1'b0);
    check("hold_pcd", PCD, 32'h04);
    step(0, 1, 1, 32'h200, 0);
    check("hold_flush_valid", ValidD, 1'b0);
    check("hold_resume_addr", imem_addr, 32'h200);
    step(0, 0, 0, 0, 1);
    check("hold_target_pcd", PCD, 32'h200);
    check("hold_target_valid", ValidD, 1'b1);

    // Reset mid-wait with a late ack, then PC wrap at the top of the address space.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_mid_wait_cnt", wait_cnt, 16'd2);
    step(1, 0, 0, 0, 1, 1'b1);
    check("rst_late_ack_valid", ValidD, 1'b0);
    check("rst_late_ack_wait", wait_cnt, 16'd0);
    check("rst_first_addr", imem_addr, RESET_PC);
    step(0, 0, 0, 0, 0);
    check("rst_restart_wait", wait_cnt, 16'd1);
    step(0, 0, 0, 0, 1);
    check("rst_first_instr", InstrD, mem_word(RESET_PC));
    step(0, 0, 1, 32'hFFFF_FFFC, 1);
    check("wrap_flush_valid", ValidD, 1'b0);
    step(0, 0, 0, 0, 1);
    check("wrap_pcd", PCD, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4D, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1);
    check("wrap_after_pcd", PCD, 32'h0);

    // Saturation of the narrow counter.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    check("sat_narrow", wait_cnt_s, 3'd7);
    check("sat_wide", wait_cnt, 16'd10);

    // Random traffic against the reference model.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC),
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
